// File: rtl/mc_rdata_pack.sv
// mc_rdata_pack: packs R = AXI_DATA_WIDTH/ARRAY_DATA_WIDTH narrow array read
// beats into one AXI read beat, buffers packed words in a small FIFO and
// presents them on an AXI-style R channel, flagging the final word of a burst.
//
// Ports:
//   clk, rst            sole clock; synchronous active-high reset
//   mc_en               controller enable, gates command acceptance only
//   cmd_vld/cmd_rdy     read burst command handshake, cmd_len = beats-1
//   array_rdata_vld     array beat strobe (no backpressure), array_rdata data
//   axi_s_rvalid/rready AXI read beat handshake
//   axi_s_rdata/rlast   packed data from FIFO head, last-beat flag
//   axi_s_rpar          per-byte even parity (only with MC_RDATA_PACK_PARITY_EN)
//   busy                FSM not idle
//   ovf_err, stray_err  sticky errors, cleared on next accepted command
//
// Build option: define MC_RDATA_PACK_PARITY_EN to add axi_s_rpar and its
// FIFO storage.
module mc_rdata_pack #(
    parameter int ARRAY_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH   = 256,
    parameter int AXI_LEN_WIDTH    = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mc_en,
    input  logic                        cmd_vld,
    output logic                        cmd_rdy,
    input  logic [AXI_LEN_WIDTH-1:0]    cmd_len,
    input  logic                        array_rdata_vld,
    input  logic [ARRAY_DATA_WIDTH-1:0] array_rdata,
    output logic                        axi_s_rvalid,
    input  logic                        axi_s_rready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_s_rdata,
    output logic                        axi_s_rlast,
`ifdef MC_RDATA_PACK_PARITY_EN
    output logic [AXI_DATA_WIDTH/8-1:0] axi_s_rpar,
`endif
    output logic                        busy,
    output logic                        ovf_err,
    output logic                        stray_err
);
    localparam int R      = AXI_DATA_WIDTH / ARRAY_DATA_WIDTH;
    localparam int LANE_W = (R > 1) ? $clog2(R) : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AXI_LEN_WIDTH + 1;
`ifdef MC_RDATA_PACK_PARITY_EN
    localparam int PAR_W  = AXI_DATA_WIDTH / 8;
    localparam int ENT_W  = AXI_DATA_WIDTH + 1 + PAR_W;
`else
    localparam int ENT_W  = AXI_DATA_WIDTH + 1;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PACK  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef logic [PW:0] ptr_t;

    logic [1:0]                           state_q;
    logic [AXI_LEN_WIDTH-1:0]             len_q;
    logic [LANE_W-1:0]                    lane_q;
    logic [CW-1:0]                        word_q;
    logic [R-1:0][ARRAY_DATA_WIDTH-1:0]   asm_q, asm_next;
    logic [AXI_DATA_WIDTH-1:0]            word_flat;
    ptr_t                                 wr_q, rd_q;
    logic [ENT_W-1:0]                     mem [FIFO_DEPTH];
    logic [ENT_W-1:0]                     push_ent, head;
    logic                                 ovf_q, stray_q;

    logic accept, beat, lane_last, word_done, is_last;
    logic empty, full, pop, push, drop, head_last;

    assign cmd_rdy   = (state_q == S_IDLE) && mc_en;
    assign accept    = cmd_vld && cmd_rdy;
    assign beat      = (state_q == S_PACK) && array_rdata_vld;
    assign lane_last = lane_q == LANE_W'(R - 1);
    assign word_done = beat && lane_last;
    assign is_last   = word_q == {1'b0, len_q};

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign pop   = !empty && axi_s_rready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push  = word_done && (!full || pop);
    assign drop  = word_done && full && !pop;

    // Completed word includes the beat arriving this cycle.
    always_comb begin
        asm_next         = asm_q;
        asm_next[lane_q] = array_rdata;
    end
    assign word_flat = asm_next;

`ifdef MC_RDATA_PACK_PARITY_EN
    logic [PAR_W-1:0] par;
    always_comb begin
        par = '0;
        for (int i = 0; i < PAR_W; i++) par[i] = ^word_flat[8*i +: 8];
    end
    assign push_ent   = {par, is_last, word_flat};
    assign axi_s_rpar = empty ? '0 : head[ENT_W-1 -: PAR_W];
`else
    assign push_ent = {is_last, word_flat};
`endif

    assign head         = mem[rd_q[PW-1:0]];
    assign head_last    = head[AXI_DATA_WIDTH];
    // Outputs gated by empty so the unreset storage never leaks out.
    assign axi_s_rvalid = !empty;
    assign axi_s_rdata  = empty ? '0 : head[AXI_DATA_WIDTH-1:0];
    assign axi_s_rlast  = !empty && head_last;
    assign busy         = state_q != S_IDLE;
    assign ovf_err      = ovf_q;
    assign stray_err    = stray_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_q[PW-1:0]] <= push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            asm_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            case (state_q)
                S_PACK: if (beat) begin
                    asm_q  <= asm_next;
                    lane_q <= lane_last ? '0 : lane_q + LANE_W'(1);
                    if (lane_last) begin
                        // Advances even when the word is dropped on overflow.
                        word_q <= word_q + CW'(1);
                        if (is_last) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: if (pop && head_last) state_q <= S_IDLE;
                default: ;
            endcase
            if (array_rdata_vld && state_q != S_PACK) stray_q <= 1'b1;
            if (drop) ovf_q <= 1'b1;
            if (push) wr_q <= wr_q + ptr_t'(1);
            if (pop)  rd_q <= rd_q + ptr_t'(1);
            // Accept only happens in IDLE; its clears take priority.
            if (accept) begin
                len_q   <= cmd_len;
                lane_q  <= '0;
                word_q  <= '0;
                ovf_q   <= 1'b0;
                stray_q <= 1'b0;
                state_q <= S_PACK;
            end
        end
    end
endmodule

// File: tb/tb_mc_rdata_pack.sv
module tb_mc_rdata_pack;
    localparam int W = 64, AW = 256, LW = 8, DEPTH = 4, R = AW / W;

    logic clk = 1'b0, rst = 1'b1, mc_en = 1'b0, cmd_vld = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic avld = 1'b0;
    logic [W-1:0] adata = '0;
    logic rready = 1'b0;
    logic cmd_rdy, rvalid, rlast, busy, ovf_err, stray_err;
    logic [AW-1:0] rdata;
`ifdef MC_RDATA_PACK_PARITY_EN
    logic [AW/8-1:0] rpar;
`endif

    always #5 clk = ~clk;

    mc_rdata_pack dut (
        .clk(clk), .rst(rst), .mc_en(mc_en), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_len(cmd_len), .array_rdata_vld(avld), .array_rdata(adata),
        .axi_s_rvalid(rvalid), .axi_s_rready(rready), .axi_s_rdata(rdata),
        .axi_s_rlast(rlast),
`ifdef MC_RDATA_PACK_PARITY_EN
        .axi_s_rpar(rpar),
`endif
        .busy(busy), .ovf_err(ovf_err), .stray_err(stray_err));

    int checks = 0, failures = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask
    task automatic chkw(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask
    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Behavioural model: beats gathered in a queue, words in a bounded queue.
    typedef struct packed { logic [AW-1:0] d; logic l; } ent_t;
    ent_t mq[$];
    logic [W-1:0] mbeats[$];
    int m_mode = 0;  // 0 idle, 1 collecting beats, 2 waiting for last pop
    int m_len = 0, m_words = 0, nxt;
    bit m_ovf = 0, m_stray = 0, m_lastdrop = 0, popd, have_push;
    ent_t pw, h;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; mq.delete(); mbeats.delete();
            m_words = 0; m_ovf = 0; m_stray = 0; m_lastdrop = 0;
        end else begin
            nxt = m_mode;
            have_push = 0;
            popd = (mq.size() > 0) && rready;
            if (avld) begin
                if (m_mode == 1) begin
                    mbeats.push_back(adata);
                    if (mbeats.size() == R) begin
                        pw.d = '0;
                        for (int i = 0; i < R; i++) pw.d[i*W +: W] = mbeats[i];
                        pw.l = (m_words == m_len);
                        if (mq.size() < DEPTH || popd) have_push = 1;
                        else begin
                            m_ovf = 1;
                            if (pw.l) m_lastdrop = 1;
                        end
                        m_words++;
                        mbeats.delete();
                        if (pw.l) nxt = 2;
                    end
                end else m_stray = 1;
            end
            if (popd) begin
                h = mq.pop_front();
                if (m_mode == 2 && h.l) nxt = 0;
            end
            if (have_push) mq.push_back(pw);
            if (m_mode == 0 && mc_en && cmd_vld) begin
                nxt = 1; m_len = int'(cmd_len); m_words = 0; mbeats.delete();
                m_ovf = 0; m_stray = 0; m_lastdrop = 0;
            end
            m_mode = nxt;
        end
    end

    // DUT-side pop accounting for burst-level expectations.
    int n_pop = 0, n_last = 0, last_idx = 0;
    always @(posedge clk) begin
        if (!rst && rvalid && rready) begin
            n_pop++;
            if (rlast) begin n_last++; last_idx = n_pop; end
        end
    end

    bit chk_en = 0;
    logic [AW/8-1:0] exp_par;
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("rvalid", rvalid, mq.size() > 0);
            if (mq.size() > 0) begin
                chkw("rdata", rdata, mq[0].d);
                chk1("rlast", rlast, mq[0].l);
            end else begin
                chkw("rdata_idle", rdata, '0);
                chk1("rlast_idle", rlast, 1'b0);
            end
`ifdef MC_RDATA_PACK_PARITY_EN
            exp_par = '0;
            if (mq.size() > 0)
                for (int i = 0; i < AW/8; i++) exp_par[i] = ^mq[0].d[8*i +: 8];
            chkw("rpar", AW'(rpar), AW'(exp_par));
`endif
            chk1("busy", busy, m_mode != 0);
            chk1("ovf_err", ovf_err, m_ovf);
            chk1("stray_err", stray_err, m_stray);
            chk1("cmd_rdy", cmd_rdy, (m_mode == 0) && mc_en);
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic cmd(input int len);
        mc_en = 1; cmd_vld = 1; cmd_len = LW'(len);
        tick;
        cmd_vld = 0;
    endtask
    task automatic beat(input logic [W-1:0] d);
        avld = 1; adata = d;
        tick;
        avld = 0;
    endtask
    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && m_mode != 0; i++) tick;
        if (m_mode != 0 && m_lastdrop) begin
            rst = 1; tick; rst = 0;
        end
        chk1("idle_reached", m_mode == 0, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1 chk_en = 1;
    end

    logic [AW-1:0] exp_w;
    int len, nb, sent;
    bit lowrr;

    initial begin
        tick; tick;
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_rdata", rdata, '0);
        chk1("rst_ovf", ovf_err, 1'b0);
        chk1("rst_stray", stray_err, 1'b0);
        rst = 0; mc_en = 1;
        tick;
        chk1("rst_cmd_rdy", cmd_rdy, 1'b1);

        // Single-word burst, lane 0 lands in the low bits.
        rready = 1;
        cmd(0);
        beat(64'h1); beat(64'h2); beat(64'h3); beat(64'h4);
        exp_w = {64'h4, 64'h3, 64'h2, 64'h1};
        chk1("b37_rvalid", rvalid, 1'b1);
        chkw("b37_rdata", rdata, exp_w);
        chk1("b37_rlast", rlast, 1'b1);
        tick;
        chk1("b37_busy_low", busy, 1'b0);
        chk1("b37_rvalid_low", rvalid, 1'b0);

        // 33-word burst with a beat every other cycle.
        n_pop = 0; n_last = 0; last_idx = 0;
        cmd(32);
        for (int i = 0; i < 132; i++) begin
            beat({$urandom, $urandom});
            tick;
        end
        wait_idle(20);
        chki("b38_pops", n_pop, 33);
        chki("b38_rlast_cnt", n_last, 1);
        chki("b38_rlast_idx", last_idx, 33);
        chk1("b38_ovf", ovf_err, 1'b0);

        // Overflow: 8 words into a 4-deep FIFO with no reader.
        rready = 0;
        cmd(7);
        for (int i = 0; i < 32; i++) begin
            beat({32'h0, $urandom});
            if (i == 15) chk1("b39_ovf_4th", ovf_err, 1'b0);
            if (i == 19) chk1("b39_ovf_5th", ovf_err, 1'b1);
        end
        n_pop = 0; n_last = 0;
        rready = 1;
        for (int i = 0; i < 8; i++) tick;
        chki("b39_pops", n_pop, 4);
        chki("b39_rlast", n_last, 0);
        chk1("b39_still_busy", busy, 1'b1);
        rst = 1; tick; rst = 0;
        chk1("b39_rst_busy", busy, 1'b0);

        // Stray beat while idle.
        beat(64'hdead);
        chk1("b40_stray", stray_err, 1'b1);
        chk1("b40_rvalid", rvalid, 1'b0);
        cmd(0);
        chk1("b40_clear", stray_err, 1'b0);
        for (int i = 0; i < R; i++) beat(64'(i));
        wait_idle(10);

        // Reset mid-burst discards everything.
        cmd(1);
        for (int i = 0; i < 6; i++) beat(64'(100 + i));
        rst = 1; tick; rst = 0;
        chk1("b41_rvalid", rvalid, 1'b0);
        chk1("b41_busy", busy, 1'b0);
        rready = 0;
        cmd(0);
        beat(64'h11); beat(64'h22); beat(64'h33); beat(64'h44);
        exp_w = {64'h44, 64'h33, 64'h22, 64'h11};
        chkw("b41_rdata", rdata, exp_w);
        chk1("b41_rlast", rlast, 1'b1);
        rready = 1;
        wait_idle(10);

`ifdef MC_RDATA_PACK_PARITY_EN
        rready = 0;
        cmd(0);
        beat(64'h07); beat(64'h0); beat(64'h0); beat(64'h0);
        chk1("b42_par_07", rpar[0], 1'b1);
        rready = 1; wait_idle(10); rready = 0;
        cmd(0);
        beat(64'h03); beat(64'h0); beat(64'h0); beat(64'h0);
        chk1("b42_par_03", rpar[0], 1'b0);
        rready = 1; wait_idle(10);
`endif

        // Randomized bursts with ready/enable noise and stray beats.
        for (int b = 0; b < 40; b++) begin
            if ($urandom_range(0, 7) == 0) beat({$urandom, $urandom});
            len = $urandom_range(0, 5);
            cmd(len);
            lowrr = ($urandom_range(0, 3) == 0);
            nb = (len + 1) * R;
            sent = 0;
            for (int c = 0; c < 2000 && sent < nb; c++) begin
                avld = ($urandom_range(0, 2) != 0);
                adata = {$urandom, $urandom};
                rready = lowrr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                mc_en = ($urandom_range(0, 7) != 0);
                cmd_vld = ($urandom_range(0, 3) == 0);
                cmd_len = LW'($urandom);
                tick;
                if (avld) sent++;
            end
            avld = 0; cmd_vld = 0; mc_en = 1; rready = 1;
            wait_idle(50);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
